// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Used by dmem_arbiter and dmem_rr_pick.
package dmem_pkg;

    localparam int unsigned DMEM_BYTES  = 1024;
    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_CNT_W  = 4;

    localparam logic M_LSU = 1'b0;
    localparam logic M_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_txn_t;

    // A word access touches addr..addr+3; compute in 33 bits so a wrap cannot look legal.
    function automatic logic addr_oob(input logic [DMEM_ADDR_W-1:0] addr,
                                      input int unsigned mem_bytes);
        return ({1'b0, addr} + 33'd3) >= 33'(mem_bytes);
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way request picker.
// DMEM_ARB_FIXED_PRIO_EN selects fixed priority (master 0 wins ties); default is round-robin.
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       id
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        valid = |req;
        id    = M_LSU;
        if (req == 2'b10) begin
            id = M_DBG;
        end else if (req == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            id = M_LSU;
`else
            id = ~last_grant;
`endif
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single-port data memory.
// Optional DMEM_ARB_FIXED_PRIO_EN (in dmem_rr_pick) switches ties to fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = DMEM_ADDR_W,
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter int unsigned MEM_BYTES   = DMEM_BYTES,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = DMEM_CNT_W;

    dmem_state_e       state_q, state_d;
    dmem_txn_t         txn_q, txn_d, pick_txn;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        rerr_q, rerr_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              pick_valid;
    logic              pick_id;
    logic [1:0]        gnt_c;

    dmem_rr_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .id         (pick_id)
    );

    // Request fields of the picked master, widened to the internal payload.
    always_comb begin
        if (pick_id == M_DBG) begin
            pick_txn.we    = m1_we;
            pick_txn.addr  = DMEM_ADDR_W'(m1_addr);
            pick_txn.wdata = DMEM_DATA_W'(m1_wdata);
        end else begin
            pick_txn.we    = m0_we;
            pick_txn.addr  = DMEM_ADDR_W'(m0_addr);
            pick_txn.wdata = DMEM_DATA_W'(m0_wdata);
        end
    end

    // Next state; out-of-range accesses spend one dead ACCESS cycle with the port idle,
    // so their error response lands two cycles after the grant.
    always_comb begin
        state_d      = state_q;
        txn_d        = txn_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        gnt_c        = 2'b00;
        rvalid_d     = 2'b00;
        rerr_d       = 2'b00;
        rdata0_d     = '0;
        rdata1_d     = '0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid && !rst) begin
                    gnt_c[pick_id] = 1'b1;
                    id_d           = pick_id;
                    txn_d          = pick_txn;
                    err_d          = addr_oob(pick_txn.addr, MEM_BYTES);
                    cnt_d          = err_d ? '0 : CNT_W'(HOLD_CYCLES - 1);
                    state_d        = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d          = ST_DONE;
                    rvalid_d[id_q]   = 1'b1;
                    rerr_d[id_q]     = err_q;
                    if (!err_q && !txn_q.we) begin
                        if (id_q == M_LSU) rdata0_d = mem_rdata;
                        else               rdata1_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                last_grant_d = id_q;
                err_d        = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Memory port is registered from the next state; write strobe only on the last hold cycle.
        if (state_d == ST_ACCESS && !err_d) begin
            mem_addr_d  = ADDR_W'(txn_d.addr);
            mem_wdata_d = DATA_W'(txn_d.wdata);
            mem_we_d    = txn_d.we && (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            txn_q        <= '0;
            last_grant_q <= M_DBG;
            id_q         <= M_LSU;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rvalid_q     <= 2'b00;
            rerr_q       <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            txn_q        <= txn_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rvalid_q     <= rvalid_d;
            rerr_q       <= rerr_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign m0_gnt    = gnt_c[0];
    assign m1_gnt    = gnt_c[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = rerr_q[0];
    assign m1_err    = rerr_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (hold 1 and hold 3) against a transaction-level model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic        req      [2][2];
    logic        we       [2][2];
    logic [31:0] addr     [2][2];
    logic [31:0] wdata    [2][2];
    logic        gnt      [2][2];
    logic        rvalid   [2][2];
    logic        err      [2][2];
    logic [31:0] rdata    [2][2];
    logic        mem_we   [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata[2];
    logic        mem_init;

    logic [7:0]  mem      [2][1024];
    logic [7:0]  ref_mem  [2][1024];
    logic        last_g   [2];
    logic [31:0] pool     [8] = '{32'h010, 32'h020, 32'h101, 32'h3FC, 32'h3FB, 32'h000, 32'h202, 32'h2F3};

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(.HOLD_CYCLES(1)) u_dut_h1 (
        .clk(clk), .rst(rst[0]),
        .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
        .m0_gnt(gnt[0][0]), .m0_rvalid(rvalid[0][0]), .m0_rdata(rdata[0][0]), .m0_err(err[0][0]),
        .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
        .m1_gnt(gnt[0][1]), .m1_rvalid(rvalid[0][1]), .m1_rdata(rdata[0][1]), .m1_err(err[0][1]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    dmem_arbiter #(.HOLD_CYCLES(3)) u_dut_h3 (
        .clk(clk), .rst(rst[1]),
        .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
        .m0_gnt(gnt[1][0]), .m0_rvalid(rvalid[1][0]), .m0_rdata(rdata[1][0]), .m0_err(err[1][0]),
        .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
        .m1_gnt(gnt[1][1]), .m1_rvalid(rvalid[1][1]), .m1_rdata(rdata[1][1]), .m1_err(err[1][1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic logic [7:0] init_byte(input int k);
        return 8'((k * 37) ^ (k >> 3) ^ 8'h5A);
    endfunction

    // Little-endian byte memories behind each instance.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            mem_rdata[g] = {mem[g][10'(mem_addr[g] + 32'd3)], mem[g][10'(mem_addr[g] + 32'd2)],
                            mem[g][10'(mem_addr[g] + 32'd1)], mem[g][10'(mem_addr[g])]};
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int g = 0; g < 2; g++)
                for (int k = 0; k < 1024; k++) mem[g][k] <= init_byte(k);
        end else begin
            for (int g = 0; g < 2; g++)
                if (mem_we[g])
                    for (int j = 0; j < 4; j++)
                        mem[g][10'(mem_addr[g] + 32'(j))] <= mem_wdata[g][8*j +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic bit oob(input logic [31:0] a);
        return (64'(a) + 64'd3) >= 64'd1024;
    endfunction

    function automatic logic [31:0] ref_read(input int i, input logic [31:0] a);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = ref_mem[i][10'(a + 32'(j))];
        return r;
    endfunction

    task automatic ref_write(input int i, input logic [31:0] a, input logic [31:0] d);
        for (int j = 0; j < 4; j++) ref_mem[i][10'(a + 32'(j))] = d[8*j +: 8];
    endtask

    function automatic bit model_pick(input int i, input logic [1:0] rq);
        if (rq == 2'b01) return 1'b0;
        if (rq == 2'b10) return 1'b1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return !last_g[i];
`endif
    endfunction

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 15);
        if (r == 0) return 32'h3FD + 32'($urandom_range(0, 2));
        if (r == 1) return $urandom;
        if (r < 8)  return pool[$urandom_range(0, 7)];
        return 32'($urandom_range(0, 1020));
    endfunction

    task automatic check_all_zero(input int i, input string tag);
        check_eq({tag, "_flags"}, 32'({mem_we[i], gnt[i][0], gnt[i][1], rvalid[i][0],
                                      rvalid[i][1], err[i][0], err[i][1]}), 32'd0);
        check_eq({tag, "_bus"}, mem_addr[i] | mem_wdata[i] | rdata[i][0] | rdata[i][1], 32'd0);
    endtask

    // One access from IDLE: grant, hold window, response; optional one-cycle poke by the idle master.
    task automatic transact(input int i, input logic [1:0] rq, input bit poke);
        int          h = (i == 1) ? 3 : 1;
        bit          w = model_pick(i, rq);
        logic        twe;
        logic [31:0] ta, twd, exp_rd;
        bit          terr;
        req[i][0] = rq[0];
        req[i][1] = rq[1];
        smp();
        check_eq("gnt_winner", 32'(gnt[i][w]), 32'd1);
        check_eq("gnt_loser", 32'(gnt[i][!w]), 32'd0);
        check_eq("rvalid_at_gnt", 32'({rvalid[i][0], rvalid[i][1]}), 32'd0);
        twe    = we[i][w];
        ta     = addr[i][w];
        twd    = wdata[i][w];
        terr   = oob(ta);
        exp_rd = (twe || terr) ? 32'd0 : ref_read(i, ta);
        adv();
        req[i][0] = 1'b0;
        req[i][1] = 1'b0;
        if (terr) begin
            smp();
            check_eq("err_port_idle", 32'(mem_we[i]) | mem_addr[i] | mem_wdata[i], 32'd0);
            check_eq("err_early_rvalid", 32'(rvalid[i][w]), 32'd0);
            adv();
        end else begin
            for (int k = 1; k <= h; k++) begin
                smp();
                check_eq("mem_addr", mem_addr[i], ta);
                check_eq("mem_wdata", mem_wdata[i], twd);
                check_eq("mem_we", 32'(mem_we[i]), 32'(twe && k == h));
                check_eq("busy_gnt", 32'({gnt[i][0], gnt[i][1]}), 32'd0);
                check_eq("busy_rvalid", 32'(rvalid[i][w]), 32'd0);
                adv();
                if (poke) begin
                    we[i][!w]    = 1'b1;
                    addr[i][!w]  = 32'($urandom_range(0, 1020));
                    req[i][!w]   = (k == 1);
                end
            end
        end
        if (twe && !terr) ref_write(i, ta, twd);
        smp();
        check_eq("rvalid", 32'(rvalid[i][w]), 32'd1);
        check_eq("err", 32'(err[i][w]), 32'(terr));
        check_eq("rdata", rdata[i][w], exp_rd);
        check_eq("other_resp", 32'(rvalid[i][!w]) | rdata[i][!w], 32'd0);
        check_eq("done_quiet", 32'({gnt[i][0], gnt[i][1], mem_we[i]}) | mem_addr[i], 32'd0);
        last_g[i] = w;
        adv();
    endtask

    task automatic set_fields(input int i, input int m, input logic w_en,
                              input logic [31:0] a, input logic [31:0] d);
        we[i][m]    = w_en;
        addr[i][m]  = a;
        wdata[i][m] = d;
    endtask

    // Both masters held high on instance 0; expect alternation (or m0 always) at hold+2 spacing.
    task automatic held_high_test();
        int   n_g = 0;
        int   prev_t = 0;
        bit   exp_w;
        set_fields(0, 0, 1'b0, 32'h100, 32'h0);
        set_fields(0, 1, 1'b0, 32'h104, 32'h0);
        req[0][0] = 1'b1;
        req[0][1] = 1'b1;
        for (int c = 0; c < 40 && n_g < 4; c++) begin
            smp();
            if (gnt[0][0] || gnt[0][1]) begin
                exp_w = model_pick(0, 2'b11);
                check_eq("hold_both_gnt", 32'(gnt[0][0] && gnt[0][1]), 32'd0);
                check_eq("hold_order", 32'(gnt[0][1]), 32'(exp_w));
                if (n_g > 0) check_eq("hold_spacing", 32'(c - prev_t), 32'd3);
                last_g[0] = exp_w;
                prev_t = c;
                n_g++;
            end
            if (n_g < 4) adv();
        end
        check_eq("hold_grants", 32'(n_g), 32'd4);
        adv();
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        adv();
        adv();
    endtask

    // Reset in the second hold cycle of a write on instance 1: no strobe, no response, memory intact.
    task automatic reset_mid_test();
        set_fields(1, 0, 1'b1, 32'h040, 32'hCAFE_F00D);
        req[1][0] = 1'b1;
        smp();
        check_eq("rst_gnt", 32'(gnt[1][0]), 32'd1);
        adv();
        req[1][0] = 1'b0;
        smp();
        check_eq("rst_acc1_addr", mem_addr[1], 32'h040);
        check_eq("rst_acc1_we", 32'(mem_we[1]), 32'd0);
        adv();
        rst[1] = 1'b1;
        smp();
        check_eq("rst_acc2_we", 32'(mem_we[1]), 32'd0);
        adv();
        rst[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            smp();
            check_all_zero(1, "post_rst");
            adv();
        end
        last_g[1] = 1'b1;
        set_fields(1, 0, 1'b0, 32'h040, 32'h0);
        transact(1, 2'b01, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i]    = 1'b1;
            last_g[i] = 1'b1;
            for (int m = 0; m < 2; m++) begin
                req[i][m] = 1'b0;
                set_fields(i, m, 1'b0, 32'h0, 32'h0);
            end
            for (int k = 0; k < 1024; k++) ref_mem[i][k] = init_byte(k);
        end
        mem_init = 1'b1;
        adv();
        adv();
        smp();
        check_all_zero(0, "reset_h1");
        check_all_zero(1, "reset_h3");
        adv();
        mem_init = 1'b0;
        rst[0]   = 1'b0;
        rst[1]   = 1'b0;

        set_fields(0, 0, 1'b1, 32'h010, 32'hDEAD_BEEF);
        transact(0, 2'b01, 1'b0);
        set_fields(0, 0, 1'b0, 32'h010, 32'h0);
        transact(0, 2'b01, 1'b0);
        check_eq("readback_ref", ref_read(0, 32'h010), 32'hDEAD_BEEF);
        set_fields(0, 1, 1'b0, 32'h3FE, 32'h0);
        transact(0, 2'b10, 1'b0);
        held_high_test();

        set_fields(1, 0, 1'b1, 32'h020, 32'h1234_5678);
        transact(1, 2'b01, 1'b0);
        set_fields(1, 0, 1'b0, 32'h020, 32'h0);
        transact(1, 2'b01, 1'b1);
        reset_mid_test();

        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 150; n++) begin
                logic [1:0] rq = 2'($urandom_range(1, 3));
                for (int m = 0; m < 2; m++)
                    set_fields(i, m, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                transact(i, rq, (i == 1) && (rq != 2'b11) && ($urandom_range(0, 7) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
